// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and helpers for the sram-like bus responder
package mem_bus_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
  // size 3 falls through to a full-word enable
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    byte_en = size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/sram_req_fifo.sv
// sram_req_fifo: in-order request queue with circular pointers
module sram_req_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  mem_req_t                     din,
  output mem_req_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  mem_req_t slots [DEPTH];
  logic [PW-1:0] rp, wp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = slots[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (do_push) slots[wp] <= din;
      if (do_push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: word-array memory answering sram-like requests in order after DELAY wait cycles
module sram_like_responder
  import mem_bus_pkg::*;
#(
  parameter int IDX_W  = 12,
  parameter int DELAY  = 2,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int CW = DELAY > 0 ? $clog2(DELAY + 1) : 1;
  localparam int QW = $clog2(QDEPTH + 1);
  mem_req_t head;
  logic full, empty, push, pop, nxt;
  logic [QW-1:0] count;
  resp_state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [2**IDX_W];
  logic [IDX_W-1:0] idx;
  logic [3:0] be;
  logic unused_bits;
  sram_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din('{wr: wr, size: size, addr: addr, wdata: wdata}),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign addr_ok = !reset && count != QW'(QDEPTH);
  assign push = req && addr_ok;
  assign pop = state == RESP;
  assign data_ok = state == RESP;
  assign idx = head.addr[IDX_W+1:2];
  assign be = byte_en(head.size, head.addr[1:0]);
  assign rdata = data_ok && !head.wr ? mem[idx] : '0;
  // an accept at this edge counts as pending work, which gives N+DELAY+1 latency from idle
  assign nxt = push || (state == RESP ? count > QW'(1) : !empty);
  assign unused_bits = ^{head.addr[31:IDX_W+2], full};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) state <= RESP;
    end else begin
      state <= !nxt ? IDLE : DELAY == 0 ? RESP : WAIT;
      cnt <= CW'(DELAY);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && head.wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= head.wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: DELAY=2 and DELAY=0 responders checked against a transaction-level model
module tb_sram_like_responder;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic [1:0] req, wr, addr_ok, data_ok;
  logic [1:0] size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  sram_like_responder #(.IDX_W(12), .DELAY(2), .QDEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));
  sram_like_responder #(.IDX_W(12), .DELAY(0), .QDEPTH(2)) u_d0 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    longint      due;
  } ent_t;
  ent_t q0[$];
  ent_t q1[$];
  logic [31:0] mm [2][4096];
  bit kn [2][4096];
  longint last_due [2];
  longint cyc;
  int nrun, nfail;
  longint lc [2][64];
  logic [31:0] ld [2][64];
  int ln [2];
  longint acc_c [2];
  int nacc [2];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one clock of the model: compare outputs, then apply the accept/response rules for this edge
  task automatic step();
    #2;
    for (int u = 0; u < 2; u++) begin
      ent_t q[$];
      ent_t e;
      int dl, ix, lo, n;
      logic eok, edk;
      longint due;
      if (u == 0) q = q0; else q = q1;
      dl = u == 0 ? 2 : 0;
      eok = !reset && q.size() < 2;
      edk = q.size() > 0 && q[0].due == cyc;
      check($sformatf("addr_ok u%0d c%0d", u, cyc), 32'(addr_ok[u]), 32'(eok));
      if (!reset || !edk) check($sformatf("data_ok u%0d c%0d", u, cyc), 32'(data_ok[u]), 32'(edk));
      if (data_ok[u]) begin
        lc[u][ln[u] % 64] = cyc;
        ld[u][ln[u] % 64] = rdata[u];
        ln[u]++;
      end
      if (edk && !reset) begin
        e = q.pop_front();
        ix = int'(e.a[13:2]);
        if (e.wr) begin
          check($sformatf("wr rdata u%0d c%0d", u, cyc), rdata[u], 32'h0);
          lo = e.sz == 2'd0 ? int'(e.a[1:0]) : e.sz == 2'd1 ? (e.a[1] ? 2 : 0) : 0;
          n = e.sz == 2'd0 ? 1 : e.sz == 2'd1 ? 2 : 4;
          for (int i = lo; i < lo + n; i++) mm[u][ix][8*i +: 8] = e.wd[8*i +: 8];
          if (n == 4) kn[u][ix] = 1;
        end else if (kn[u][ix]) begin
          check($sformatf("rdata u%0d c%0d", u, cyc), rdata[u], mm[u][ix]);
        end
      end
      if (req[u] && eok) begin
        due = cyc + dl + 1;
        if (last_due[u] + dl + 1 > due) due = last_due[u] + dl + 1;
        q.push_back('{wr: wr[u], sz: size[u], a: addr[u], wd: wdata[u], due: due});
        last_due[u] = due;
        acc_c[u] = cyc;
        nacc[u]++;
      end
      if (reset) begin
        q.delete();
        last_due[u] = -100;
      end
      if (u == 0) q0 = q; else q1 = q;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic set(input int u, input logic r, input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    req[u] = r;
    wr[u] = w;
    size[u] = s;
    addr[u] = a;
    wdata[u] = d;
  endtask
  task automatic accept(input int u);
    int a0;
    a0 = nacc[u];
    for (int k = 0; k < 20 && nacc[u] == a0; k++) step();
    check($sformatf("accept u%0d", u), 32'(nacc[u]), 32'(a0 + 1));
  endtask
  task automatic wait_resp(input int u, input int target);
    for (int k = 0; k < 40 && ln[u] < target; k++) step();
    check($sformatf("resp count u%0d", u), 32'(ln[u]), 32'(target));
  endtask
  task automatic xact(input int u, input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output longint lat);
    int n0;
    n0 = ln[u];
    set(u, 1, w, s, a, d);
    accept(u);
    req[u] = 0;
    wait_resp(u, n0 + 1);
    rd = ld[u][n0 % 64];
    lat = lc[u][n0 % 64] - acc_c[u];
  endtask
  initial begin
    logic [31:0] rd;
    longint lat;
    longint ac [4];
    int n0;
    nrun = 0;
    nfail = 0;
    cyc = 0;
    for (int u = 0; u < 2; u++) begin
      set(u, 0, 0, 0, 0, 0);
      last_due[u] = -100;
      ln[u] = 0;
      nacc[u] = 0;
    end
    @(posedge clk);
    #1;
    step();
    step();
    reset = 0;
    #2;
    check("rst data_ok", 32'(data_ok[0]), 32'h0);
    check("rst rdata", rdata[0], 32'h0);
    check("rst data_ok d0", 32'(data_ok[1]), 32'h0);
    // basic write/read latency with DELAY=2
    xact(0, 1, 2, 32'h100, 32'hDEADBEEF, rd, lat);
    check("wr lat", 32'(lat), 32'd3);
    xact(0, 0, 2, 32'h100, 0, rd, lat);
    check("rd lat", 32'(lat), 32'd3);
    check("rd data", rd, 32'hDEADBEEF);
    // byte and half lane merges
    xact(0, 1, 2, 32'h100, 32'h11223344, rd, lat);
    xact(0, 1, 0, 32'h101, 32'h0000AA00, rd, lat);
    xact(0, 0, 2, 32'h100, 0, rd, lat);
    check("byte merge", rd, 32'h1122AA44);
    xact(0, 1, 1, 32'h102, 32'h55660000, rd, lat);
    xact(0, 0, 2, 32'h100, 0, rd, lat);
    check("half merge", rd, 32'h5566AA44);
    // queue full backpressure with req held high
    xact(0, 1, 2, 32'h104, 32'h00104104, rd, lat);
    xact(0, 1, 2, 32'h108, 32'h00108108, rd, lat);
    n0 = ln[0];
    for (int k = 0; k < 3; k++) begin
      set(0, 1, 0, 2, 32'h100 + 32'(4 * k), 0);
      accept(0);
      ac[k] = acc_c[0];
    end
    req[0] = 0;
    wait_resp(0, n0 + 3);
    check("full acc1", 32'(ac[1] - ac[0]), 32'd1);
    check("full acc2", 32'(ac[2] - ac[0]), 32'd4);
    check("full first resp", 32'(lc[0][n0 % 64] - ac[0]), 32'd3);
    check("order 0", ld[0][n0 % 64], 32'h5566AA44);
    check("order 1", ld[0][(n0 + 1) % 64], 32'h00104104);
    check("order 2", ld[0][(n0 + 2) % 64], 32'h00108108);
    // write then read of the same word queued back-to-back, then an aliased address
    n0 = ln[0];
    set(0, 1, 1, 2, 32'h200, 32'hCAFEF00D);
    accept(0);
    set(0, 1, 0, 2, 32'h200, 0);
    accept(0);
    req[0] = 0;
    wait_resp(0, n0 + 2);
    check("raw", ld[0][(n0 + 1) % 64], 32'hCAFEF00D);
    xact(0, 0, 2, 32'h4200, 0, rd, lat);
    check("alias", rd, 32'hCAFEF00D);
    // reset while a write waits: it must never land
    n0 = ln[0];
    set(0, 1, 1, 2, 32'h100, 32'hA5A5A5A5);
    accept(0);
    req[0] = 0;
    step();
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    step();
    step();
    check("reset drop", 32'(ln[0]), 32'(n0));
    xact(0, 0, 2, 32'h100, 0, rd, lat);
    check("reset old", rd, 32'h5566AA44);
    // DELAY=0: single-cycle latency and back-to-back responses
    for (int k = 0; k < 4; k++) begin
      xact(1, 1, 2, 32'(4 * k), 32'h0BAD0000 + 32'(k), rd, lat);
      if (k == 0) check("d0 lat", 32'(lat), 32'd1);
    end
    n0 = ln[1];
    for (int k = 0; k < 4; k++) begin
      set(1, 1, 0, 2, 32'(4 * k), 0);
      accept(1);
      ac[k] = acc_c[1];
    end
    req[1] = 0;
    wait_resp(1, n0 + 4);
    check("d0 acc span", 32'(ac[3] - ac[0]), 32'd3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d0 cyc %0d", k), 32'(lc[1][(n0 + k) % 64] - ac[0]), 32'(k + 1));
      check($sformatf("d0 data %0d", k), ld[1][(n0 + k) % 64], 32'h0BAD0000 + 32'(k));
    end
    // random traffic over a small region with aliasing upper bits
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 8; k++) xact(u, 1, 2, 32'h100 + 32'(4 * k), $urandom, rd, lat);
    for (int t = 0; t < 400; t++) begin
      for (int u = 0; u < 2; u++)
        set(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom & 32'hFFFFC000) | (32'h100 + 32'($urandom_range(0, 31))), $urandom);
      step();
    end
    req = 0;
    for (int k = 0; k < 20; k++) step();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Memory-side responder for the sram-like bus (req/addr_ok/data_ok) that the next revision of the multi-cycle CPU uses for instruction and data fetch.
- Holds a word-addressed backing array and accepts requests into an in-order queue.
- Returns each response after a programmable wait, so CPU stall and handshake logic can be exercised against non-ideal memory.
- One instance per CPU port: instruction and data.

Parameters:
- IDX_W, 12: word-index bits; the array holds 2^IDX_W 32-bit words.
- DELAY, 2: wait cycles between a queue entry reaching the head and its data_ok (0 allowed).
- QDEPTH, 2: maximum outstanding accepted requests (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- addr  in  32  byte address
- wdata  in  32  write data, lane-aligned (byte at addr[1:0] lane)
- addr_ok  out  1  request accepted this cycle when req & addr_ok
- data_ok  out  1  one-cycle response strobe
- rdata  out  32  read word; valid only while data_ok=1 for a read

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - addr_ok=0 while reset=1.
  - data_ok=0, rdata=0, queue empty, FSM=IDLE.
  - Array contents are not reset.
- addr_ok = !reset && (count != QDEPTH). Combinational from registered count only; no dependence on req.
- Accept: at a posedge with req & addr_ok, push {wr, size, addr, wdata}. Inputs are don't-care otherwise.
- Full and pop in the same cycle: no accept that cycle. addr_ok rises the next cycle.
- Index = addr[IDX_W+1:2]; upper address bits are ignored, so addresses wrap.
- Alignment: half ignores addr[0]; word ignores addr[1:0]. No misalignment error.
- Write byte enables:
  - byte: 1 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Only enabled lanes are updated.
- Response engine FSM, with a wait counter of clog2(DELAY+1) bits:
  - IDLE: queue empty. On queue non-empty: if DELAY=0 go to RESP, else go to WAIT with cnt=DELAY.
  - WAIT: cnt decrements each cycle; when cnt==1, go to RESP.
  - RESP (one cycle): data_ok=1; the head entry executes and pops.
    - Read: rdata = full word at index, sampled this cycle.
    - Write: array updated at this edge; rdata=0.
    - Next state: if the queue still holds an entry after the pop, go to WAIT with cnt=DELAY (or RESP if DELAY=0); else IDLE.
- Latency with an idle queue: data_ok is high in cycle N+DELAY+1 after an accept edge in cycle N.
- Throughput: one response per DELAY+1 cycles; DELAY=0 gives back-to-back data_ok.
- Ordering: strictly in order. A read queued behind a write to the same word returns the written data.
- Reset mid-operation:
  - Outstanding requests are discarded with no data_ok.
  - A write not yet in RESP never reaches the array.
  - A write already in RESP in the reset cycle is also discarded (reset has priority).

Decomposition:
- Shared package mem_bus_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - resp FSM state enum {IDLE, WAIT, RESP}
  - request struct {wr, size[1:0], addr[31:0], wdata[31:0]}
  - byte-enable function
- Sub-module sram_req_fifo (QDEPTH entries of the request struct):
  - push/pop/full/empty/count
  - circular pointers with wrap at QDEPTH
  - simultaneous push+pop leaves count unchanged
- Top module: FSM, counter, array, lane merge.

Test Plan:
- DELAY=2. Accept write word addr=0x100, wdata=0xDEADBEEF at cycle 0 -> data_ok at cycle 3. Read 0x100 -> rdata=0xDEADBEEF 3 cycles after its accept.
- Write byte addr=0x101, wdata=0x0000AA00 over word 0x11223344 -> read 0x100 returns 0x1122AA44. Write half addr=0x102, wdata=0x55660000 -> read returns 0x5566AA44.
- QDEPTH=2, req held high with 3 reads -> addr_ok low after the 2nd accept. The 3rd is accepted the cycle after the 1st data_ok. Responses return in order.
- DELAY=0, 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC -> data_ok high 4 consecutive cycles starting the cycle after the first accept, with matching data.
- Write then read to addr 0x200 queued back-to-back -> read returns the new data. Addr 0x4200 with IDX_W=12 aliases to 0x200.
- Reset asserted in WAIT with a write queued -> no data_ok, addr_ok=0 during reset. A later read shows the old array value.
